// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C master arbiter.
// Holds the FSM encoding and a burst-length helper.
package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int REG_W  = 8;
    localparam int DATA_W = 8;
    localparam int BLEN_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } arb_state_e;

    // Burst length code 0..3 means 1..4 bytes.
    function automatic logic [2:0] blen_bytes(input logic [BLEN_W-1:0] code);
        return {1'b0, code} + 3'd1;
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
// Produces a one-hot winner and a valid flag.
module i2c_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    int idx;

    // Scan N positions starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between NUM_REQ requesters with round-robin
// grant, start-hold pulse, timeout supervision and read-data routing.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int START_HOLD     = 1000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                        Clk_In,
    input  logic                        Reset_In,
    input  logic [NUM_REQ-1:0]          Req_In,
    input  logic [NUM_REQ-1:0]          Req_Read_Writeb_In,
    input  logic [NUM_REQ-1:0]          Req_Burst_Singleb_In,
    input  logic [BLEN_W*NUM_REQ-1:0]   Req_Burst_Length_In,
    input  logic [ADDR_W*NUM_REQ-1:0]   Req_Slave_Address_In,
    input  logic [REG_W*NUM_REQ-1:0]    Req_Reg_Address_In,
    input  logic [DATA_W*NUM_REQ-1:0]   Req_Data_In,
    output logic [NUM_REQ-1:0]          Grant_Out,
    output logic [NUM_REQ-1:0]          Done_Out,
    output logic [NUM_REQ-1:0]          Error_Out,
    output logic [NUM_REQ-1:0]          Rd_Valid_Out,
    output logic [DATA_W-1:0]           Rd_Data_Out,
    output logic                        Busy_Out,
    output logic                        M_Start_Transfer_Out,
    output logic                        M_Burst_Singleb_Out,
    output logic                        M_Read_Writeb_Out,
    output logic [BLEN_W-1:0]           M_Burst_Length_Out,
    output logic [ADDR_W-1:0]           M_Slave_Device_Address_Out,
    output logic [REG_W-1:0]            M_Reg_Address_Out,
    output logic [DATA_W-1:0]           M_Data_Out,
    input  logic [DATA_W-1:0]           M_Data_In,
    input  logic                        M_Data_Read_Enable_In,
    input  logic                        M_Done_In
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(START_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    arb_state_e          state_q;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [HW-1:0]       hold_q;
    logic [TW-1:0]       tmo_q;
    logic [NUM_REQ-1:0]  grant_q, done_q, err_q, rdv_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                start_q, burst_q, rw_q;
    logic [BLEN_W-1:0]   blen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [REG_W-1:0]    reg_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_valid;
    logic                burst_d, rw_d;
    logic [BLEN_W-1:0]   blen_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [REG_W-1:0]    reg_d;
    logic [DATA_W-1:0]   wdata_d;

    i2c_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req_i   (Req_In),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    // Select the winner's fields and the pointer just past the winner.
    always_comb begin
        ptr_d   = ptr_q;
        rw_d    = 1'b0;
        burst_d = 1'b0;
        blen_d  = '0;
        addr_d  = '0;
        reg_d   = '0;
        wdata_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                ptr_d   = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
                rw_d    = Req_Read_Writeb_In[i];
                burst_d = Req_Burst_Singleb_In[i];
                blen_d  = Req_Burst_Length_In[i*BLEN_W +: BLEN_W];
                addr_d  = Req_Slave_Address_In[i*ADDR_W +: ADDR_W];
                reg_d   = Req_Reg_Address_In[i*REG_W +: REG_W];
                wdata_d = Req_Data_In[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            tmo_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdv_q   <= '0;
            rdata_q <= '0;
            start_q <= 1'b0;
            burst_q <= 1'b0;
            rw_q    <= 1'b0;
            blen_q  <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            rdv_q  <= '0;
            if ((state_q == S_LAUNCH || state_q == S_WAIT) &&
                rw_q && M_Data_Read_Enable_In) begin
                rdv_q   <= grant_q;
                rdata_q <= M_Data_In;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_gnt;
                        ptr_q   <= ptr_d;
                        rw_q    <= rw_d;
                        burst_q <= burst_d;
                        blen_q  <= blen_d;
                        addr_q  <= addr_d;
                        reg_q   <= reg_d;
                        wdata_q <= wdata_d;
                        start_q <= 1'b1;
                        hold_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // Saturate so a long start hold cannot wrap the timer.
                    if (tmo_q != TMO_LAST) tmo_q <= tmo_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        start_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Done takes priority over the terminal timeout cycle.
                    if (M_Done_In) begin
                        done_q  <= grant_q;
                        state_q <= S_FINISH;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= grant_q;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Grant_Out                  = grant_q;
    assign Done_Out                   = done_q;
    assign Error_Out                  = err_q;
    assign Rd_Valid_Out               = rdv_q;
    assign Rd_Data_Out                = rdata_q;
    assign Busy_Out                   = (state_q != S_IDLE);
    assign M_Start_Transfer_Out       = start_q;
    assign M_Burst_Singleb_Out        = burst_q;
    assign M_Read_Writeb_Out          = rw_q;
    assign M_Burst_Length_Out         = blen_q;
    assign M_Slave_Device_Address_Out = addr_q;
    assign M_Reg_Address_Out          = reg_q;
    assign M_Data_Out                 = wdata_q;

endmodule
